// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/ready/done handshake.
// Results appear WIDTH+1 edges after the accepting edge and hold until the next completion.
module seq_restoring_div #(
    parameter  int unsigned WIDTH = 784,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic             dbz_w;

    logic [WIDTH:0]   t_c;
    logic             ge_c;
    logic [WIDTH:0]   r_next_c;
    logic [WIDTH-1:0] q_next_c;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        t_c      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        ge_c     = (t_c >= {1'b0, d_reg});
        r_next_c = t_c;
        q_next_c = {q_reg[WIDTH-2:0], 1'b0};
        if (ge_c) begin
            r_next_c = t_c - {1'b0, d_reg};
            q_next_c = {q_reg[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            dbz_w       <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        ready <= 1'b0;
                        cnt   <= '0;
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        dbz_w <= (divisor == '0);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // WIDTH shift steps, then one edge to publish the settled result.
                    if (cnt == CW'(WIDTH)) begin
                        state       <= DONE;
                        ready       <= 1'b1;
                        done        <= 1'b1;
                        quotient    <= q_reg;
                        remainder   <= r_reg[WIDTH-1:0];
                        div_by_zero <= dbz_w;
                    end else begin
                        r_reg <= r_next_c;
                        q_reg <= q_next_c;
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Scoreboard bench for seq_restoring_div at WIDTH=8: directed vectors with hand-computed results;
// a negedge monitor pops expectations on done and checks values, latency and output hold.
module tb_seq_restoring_div;

    localparam int unsigned W   = 8;
    localparam int          LAT = W + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int last_acc = 0;
    exp_t sb[$];
    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;
    logic         hold_z = 1'b0;

    seq_restoring_div #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: pop on done, otherwise outputs must still hold the last completed result.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", 32'(quotient), 32'(e.q));
                    chk("remainder", 32'(remainder), 32'(e.r));
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    chk("latency", 32'(edge_cnt - e.acc), 32'(LAT));
                    chk("ready_in_done", 32'(ready), 32'(1));
                    hold_q = e.q;
                    hold_r = e.r;
                    hold_z = e.dbz;
                end
            end else begin
                chk("hold", {15'd0, div_by_zero, remainder, quotient}, {15'd0, hold_z, hold_r, hold_q});
            end
        end
    end

    // Wait for ready, present one request for one edge, then scramble the operands.
    task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int k;
        exp_t e;
        k = 0;
        @(negedge clk);
        while (!ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'(1));
        start    = 1'b1;
        dividend = n;
        divisor  = d;
        e.q = eq; e.r = er; e.dbz = ez; e.acc = edge_cnt + 1;
        last_acc = e.acc;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h5A;
        chk("ready_drop", 32'(ready), 32'(0));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int acc_a;
        logic [W-1:0] rn, rd;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'(1));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_outputs", {15'd0, div_by_zero, remainder, quotient}, 32'(0));

        // Basic divide
        issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        drain();

        // Back-to-back through DONE: next accept lands one edge after done
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        acc_a = last_acc;
        issue(8'd3, 8'd10, 8'd0, 8'd3, 1'b0);
        chk("b2b_gap", 32'(last_acc - acc_a), 32'(LAT + 1));
        drain();

        // Divide by zero, then a normal divide clears the flag
        issue(8'd5, 8'd0, 8'd255, 8'd5, 1'b1);
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        drain();

        // Starts while busy are ignored
        issue(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        // Reset mid-divide: no done, outputs cleared
        issue(8'd200, 8'd9, 8'd22, 8'd2, 1'b0);
        drain();
        issue(8'd77, 8'd5, 8'd15, 8'd2, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        hold_q = '0; hold_r = '0; hold_z = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'(1));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_outputs", {15'd0, div_by_zero, remainder, quotient}, 32'(0));
        repeat (12) @(negedge clk);
        issue(8'd77, 8'd5, 8'd15, 8'd2, 1'b0);
        drain();

        // Boundary vectors
        issue(8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
        issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        issue(8'd254, 8'd255, 8'd0, 8'd254, 1'b0);
        issue(8'd128, 8'd2, 8'd64, 8'd0, 1'b0);
        issue(8'd0, 8'd0, 8'd255, 8'd0, 1'b1);
        issue(8'd1, 8'd1, 8'd1, 8'd0, 1'b0);
        issue(8'd255, 8'd16, 8'd15, 8'd15, 1'b0);
        issue(8'd129, 8'd128, 8'd1, 8'd1, 1'b0);
        drain();

        // Randomised operands, including divisors 0 and 1
        for (int i = 0; i < 40; i++) begin
            rn = W'($urandom);
            case (i % 4)
                0:       rd = '0;
                1:       rd = 8'd1;
                default: rd = W'($urandom);
            endcase
            if (rd == '0) issue(rn, rd, 8'hFF, rn, 1'b1);
            else          issue(rn, rd, rn / rd, rn % rd, 1'b0);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
